// File: rtl/wbm_arb3.sv
// Three-master Wishbone arbiter: grants one master at a time to the 16-bit
// system bus, muxes its request to the slave, routes ack back to it, and ends
// stalled accesses with a one-cycle error pulse after a no-reply timeout.
module wbm_arb3 #(
    parameter int unsigned TMO_CYCLES = 255,
    parameter bit          RR         = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic [2:0]  m_cyc_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [5:0]  m_sel_i,
    input  logic [47:0] m_adr_i,
    input  logic [47:0] m_dat_i,
    output logic [15:0] m_dat_o,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    output logic [2:0]  m_gnt_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [1:0]  s_sel_o,
    output logic [15:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    output logic        tmo_o,
    output logic [15:0] tmo_adr_o
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ADR_W = 16;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

    logic [0:0]       r_state,   w_state_nx;
    logic [1:0]       r_own,     w_own_nx;
    logic [1:0]       r_last,    w_last_nx;
    logic [2:0]       r_gnt,     w_gnt_nx;
    logic [2:0]       r_err,     w_err_nx;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nx;
    logic             r_blk,     w_blk_nx;
    logic             r_tmo,     w_tmo_nx;
    logic [ADR_W-1:0] r_tmo_adr, w_tmo_adr_nx;

    logic             w_granted;
    logic             w_stall;
    logic [1:0]       w_pick;
    logic             w_own_cyc;
    logic             w_own_stb;
    logic             w_own_we;
    logic [SEL_W-1:0] w_own_sel;
    logic [ADR_W-1:0] w_own_adr;
    logic [DAT_W-1:0] w_own_dat;

    // Select the request fields of the current owner.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_sel = '0;
        w_own_adr = '0;
        w_own_dat = '0;
        case (r_own)
            2'd0: begin
                w_own_cyc = m_cyc_i[0];
                w_own_stb = m_stb_i[0];
                w_own_we  = m_we_i[0];
                w_own_sel = m_sel_i[1:0];
                w_own_adr = m_adr_i[15:0];
                w_own_dat = m_dat_i[15:0];
            end
            2'd1: begin
                w_own_cyc = m_cyc_i[1];
                w_own_stb = m_stb_i[1];
                w_own_we  = m_we_i[1];
                w_own_sel = m_sel_i[3:2];
                w_own_adr = m_adr_i[31:16];
                w_own_dat = m_dat_i[31:16];
            end
            2'd2: begin
                w_own_cyc = m_cyc_i[2];
                w_own_stb = m_stb_i[2];
                w_own_we  = m_we_i[2];
                w_own_sel = m_sel_i[5:4];
                w_own_adr = m_adr_i[47:32];
                w_own_dat = m_dat_i[47:32];
            end
            default: ;
        endcase
    end

    // Winner among requesters: rotate from the last owner, or lowest index.
    always_comb begin
        w_pick = 2'd0;
        if (RR) begin
            case (r_last)
                2'd0:    w_pick = m_cyc_i[1] ? 2'd1 : (m_cyc_i[2] ? 2'd2 : 2'd0);
                2'd1:    w_pick = m_cyc_i[2] ? 2'd2 : (m_cyc_i[0] ? 2'd0 : 2'd1);
                default: w_pick = m_cyc_i[0] ? 2'd0 : (m_cyc_i[1] ? 2'd1 : 2'd2);
            endcase
        end else begin
            w_pick = m_cyc_i[0] ? 2'd0 : (m_cyc_i[1] ? 2'd1 : 2'd2);
        end
    end

    // Slave-side bus is the owner's request, forced to zero without a grant.
    assign w_granted = (r_state == S_OWN);
    assign s_cyc_o   = w_granted & w_own_cyc;
    assign s_stb_o   = w_granted & w_own_stb & ~r_blk;
    assign s_we_o    = w_granted & w_own_we;
    assign s_sel_o   = w_granted ? w_own_sel : '0;
    assign s_adr_o   = w_granted ? w_own_adr : '0;
    assign s_dat_o   = w_granted ? w_own_dat : '0;
    assign m_ack_o   = (w_granted & s_ack_i & ~r_blk) ? r_gnt : 3'b000;
    assign m_dat_o   = s_dat_i;
    assign m_gnt_o   = r_gnt;
    assign m_err_o   = r_err;
    assign tmo_o     = r_tmo;
    assign tmo_adr_o = r_tmo_adr;

    assign w_stall   = s_stb_o & ~s_ack_i;

    // Next-state: arbitration in IDLE, release and no-reply timeout in OWN.
    always_comb begin
        w_state_nx   = r_state;
        w_own_nx     = r_own;
        w_last_nx    = r_last;
        w_gnt_nx     = r_gnt;
        w_err_nx     = 3'b000;
        w_cnt_nx     = '0;
        w_blk_nx     = r_blk;
        w_tmo_nx     = 1'b0;
        w_tmo_adr_nx = r_tmo_adr;
        case (r_state)
            S_IDLE: begin
                w_blk_nx = 1'b0;
                if (|m_cyc_i) begin
                    w_state_nx = S_OWN;
                    w_own_nx   = w_pick;
                    w_last_nx  = w_pick;
                    w_gnt_nx   = 3'b001 << w_pick;
                end
            end
            default: begin
                if (!w_own_cyc) begin
                    w_state_nx = S_IDLE;
                    w_gnt_nx   = 3'b000;
                    w_blk_nx   = 1'b0;
                end else if (w_stall && (r_cnt == TMO_LAST)) begin
                    w_err_nx     = r_gnt;
                    w_tmo_nx     = 1'b1;
                    w_tmo_adr_nx = s_adr_o;
                    w_blk_nx     = 1'b1;
                end else begin
                    w_cnt_nx = w_stall ? (r_cnt + CNT_W'(1)) : '0;
                    if (!w_own_stb) begin
                        w_blk_nx = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= S_IDLE;
            r_own     <= 2'd0;
            r_last    <= 2'd2;
            r_gnt     <= 3'b000;
            r_err     <= 3'b000;
            r_cnt     <= '0;
            r_blk     <= 1'b0;
            r_tmo     <= 1'b0;
            r_tmo_adr <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_own     <= w_own_nx;
            r_last    <= w_last_nx;
            r_gnt     <= w_gnt_nx;
            r_err     <= w_err_nx;
            r_cnt     <= w_cnt_nx;
            r_blk     <= w_blk_nx;
            r_tmo     <= w_tmo_nx;
            r_tmo_adr <= w_tmo_adr_nx;
        end
    end

endmodule

// File: tb/tb_wbm_arb3.sv
// Bench for wbm_arb3: two instances (round-robin TMO=4, fixed-priority TMO=3)
// checked every cycle against a behavioural model of the arbitration rules.
module tb_wbm_arb3;

    logic clk;
    logic rst_n;

    logic [2:0]  cyc  [2];
    logic [2:0]  stb  [2];
    logic [2:0]  we   [2];
    logic [5:0]  sel  [2];
    logic [47:0] adr  [2];
    logic [47:0] wdat [2];
    logic [15:0] sdat [2];
    logic        sack [2];

    logic [15:0] o_mdat [2];
    logic [2:0]  o_ack  [2];
    logic [2:0]  o_err  [2];
    logic [2:0]  o_gnt  [2];
    logic        o_scyc [2];
    logic        o_sstb [2];
    logic        o_swe  [2];
    logic [1:0]  o_ssel [2];
    logic [15:0] o_sadr [2];
    logic [15:0] o_sdat [2];
    logic        o_tmo  [2];
    logic [15:0] o_tadr [2];

    wbm_arb3 #(.TMO_CYCLES(4), .RR(1'b1)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .m_cyc_i(cyc[0]), .m_stb_i(stb[0]), .m_we_i(we[0]), .m_sel_i(sel[0]),
        .m_adr_i(adr[0]), .m_dat_i(wdat[0]), .m_dat_o(o_mdat[0]),
        .m_ack_o(o_ack[0]), .m_err_o(o_err[0]), .m_gnt_o(o_gnt[0]),
        .s_cyc_o(o_scyc[0]), .s_stb_o(o_sstb[0]), .s_we_o(o_swe[0]),
        .s_sel_o(o_ssel[0]), .s_adr_o(o_sadr[0]), .s_dat_o(o_sdat[0]),
        .s_dat_i(sdat[0]), .s_ack_i(sack[0]), .tmo_o(o_tmo[0]), .tmo_adr_o(o_tadr[0])
    );

    wbm_arb3 #(.TMO_CYCLES(3), .RR(1'b0)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .m_cyc_i(cyc[1]), .m_stb_i(stb[1]), .m_we_i(we[1]), .m_sel_i(sel[1]),
        .m_adr_i(adr[1]), .m_dat_i(wdat[1]), .m_dat_o(o_mdat[1]),
        .m_ack_o(o_ack[1]), .m_err_o(o_err[1]), .m_gnt_o(o_gnt[1]),
        .s_cyc_o(o_scyc[1]), .s_stb_o(o_sstb[1]), .s_we_o(o_swe[1]),
        .s_sel_o(o_ssel[1]), .s_adr_o(o_sadr[1]), .s_dat_o(o_sdat[1]),
        .s_dat_i(sdat[1]), .s_ack_i(sack[1]), .tmo_o(o_tmo[1]), .tmo_adr_o(o_tadr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Behavioural model state: who owns the bus, rotation memory, stall count.
    int          tmo_n   [2];
    bit          rr_n    [2];
    bit          mov     [2];
    int          mown    [2];
    int          mlast   [2];
    int          mcnt    [2];
    bit          mblk    [2];
    logic [2:0]  merr    [2];
    bit          mtmo    [2];
    logic [15:0] mtadr   [2];

    logic [2:0]  e_gnt  [2];
    logic [2:0]  e_ack  [2];
    logic        e_cyc  [2];
    logic        e_stb  [2];
    logic        e_we   [2];
    logic [1:0]  e_sel  [2];
    logic [15:0] e_adr  [2];
    logic [15:0] e_wdat [2];
    logic [2:0]  done   [2];
    int          ack_mode [2];
    bit          sdat_rand;

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        mov[d] = 1'b0; mown[d] = 0; mlast[d] = 2; mcnt[d] = 0; mblk[d] = 1'b0;
        merr[d] = 3'b000; mtmo[d] = 1'b0; mtadr[d] = 16'h0000; done[d] = 3'b000;
    endtask

    task automatic model_comb(input int d);
        int o;
        o = mown[d];
        if (mov[d]) begin
            e_gnt[d]  = 3'(1 << o);
            e_cyc[d]  = cyc[d][o];
            e_stb[d]  = stb[d][o] && !mblk[d];
            e_we[d]   = we[d][o];
            e_sel[d]  = sel[d][o*2 +: 2];
            e_adr[d]  = adr[d][o*16 +: 16];
            e_wdat[d] = wdat[d][o*16 +: 16];
        end else begin
            e_gnt[d] = 3'b000; e_cyc[d] = 1'b0; e_stb[d] = 1'b0; e_we[d] = 1'b0;
            e_sel[d] = 2'b00; e_adr[d] = 16'h0; e_wdat[d] = 16'h0;
        end
    endtask

    function automatic int pick(input int d);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = rr_n[d] ? (mlast[d] + k) % 3 : k - 1;
            if (cyc[d][c]) return c;
        end
        return 0;
    endfunction

    task automatic model_next(input int d);
        bit stall;
        merr[d] = 3'b000;
        mtmo[d] = 1'b0;
        if (!mov[d]) begin
            mcnt[d] = 0;
            mblk[d] = 1'b0;
            if (cyc[d] != 3'b000) begin
                mown[d] = pick(d); mlast[d] = mown[d]; mov[d] = 1'b1;
            end
        end else if (!cyc[d][mown[d]]) begin
            mov[d] = 1'b0; mcnt[d] = 0; mblk[d] = 1'b0;
        end else begin
            stall = e_stb[d] && !sack[d];
            if (stall && mcnt[d] == tmo_n[d] - 1) begin
                merr[d] = 3'(1 << mown[d]); mtmo[d] = 1'b1; mtadr[d] = e_adr[d];
                mcnt[d] = 0; mblk[d] = 1'b1;
            end else begin
                mcnt[d] = stall ? mcnt[d] + 1 : 0;
                if (!stb[d][mown[d]]) mblk[d] = 1'b0;
            end
        end
    endtask

    // Drive the slave response, then compare every output of both instances.
    task automatic settle();
        #1;
        for (int d = 0; d < 2; d++) begin
            model_comb(d);
            if (sdat_rand) sdat[d] = 16'($urandom);
            case (ack_mode[d])
                0:       sack[d] = 1'b0;
                1:       sack[d] = e_stb[d];
                default: sack[d] = e_stb[d] ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            endcase
            e_ack[d] = (mov[d] && sack[d] && !mblk[d]) ? e_gnt[d] : 3'b000;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "gnt",    o_gnt[d],  e_gnt[d]);
            chk(d, "s_cyc",  o_scyc[d], e_cyc[d]);
            chk(d, "s_stb",  o_sstb[d], e_stb[d]);
            chk(d, "s_we",   o_swe[d],  e_we[d]);
            chk(d, "s_sel",  o_ssel[d], e_sel[d]);
            chk(d, "s_adr",  o_sadr[d], e_adr[d]);
            chk(d, "s_dat",  o_sdat[d], e_wdat[d]);
            chk(d, "m_ack",  o_ack[d],  e_ack[d]);
            chk(d, "m_dat",  o_mdat[d], sdat[d]);
            chk(d, "m_err",  o_err[d],  merr[d]);
            chk(d, "tmo",    o_tmo[d],  mtmo[d]);
            chk(d, "tmo_adr", o_tadr[d], mtadr[d]);
            done[d] = e_ack[d] | merr[d];
        end
    endtask

    task automatic adv();
        if (rst_n) begin
            for (int d = 0; d < 2; d++) model_next(d);
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic idle(input int n);
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 3'b000; stb[d] = 3'b000; ack_mode[d] = 0;
        end
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) model_reset(d);
        adv();
        rst_n = 1'b1;
    endtask

    task automatic new_acc(input int d, input int m);
        stb[d][m]          = 1'b1;
        we[d][m]           = 1'($urandom);
        sel[d][m*2 +: 2]   = 2'($urandom);
        adr[d][m*16 +: 16] = 16'($urandom);
        wdat[d][m*16 +: 16] = 16'($urandom);
    endtask

    // Random master behaviour: request, complete accesses, sometimes abandon.
    task automatic agent(input int d);
        logic [2:0] g;
        g = mov[d] ? 3'(1 << mown[d]) : 3'b000;
        for (int m = 0; m < 3; m++) begin
            if (!cyc[d][m]) begin
                if ($urandom_range(3) == 0) begin
                    cyc[d][m] = 1'b1;
                    new_acc(d, m);
                end
            end else if (done[d][m]) begin
                stb[d][m] = 1'b0;
                if ($urandom_range(1) == 0) cyc[d][m] = 1'b0;
            end else if (g[m] && stb[d][m] && $urandom_range(19) == 0) begin
                cyc[d][m] = 1'b0;
                stb[d][m] = 1'b0;
            end else if (g[m] && !stb[d][m]) begin
                case ($urandom_range(3))
                    0, 1:    new_acc(d, m);
                    2:       cyc[d][m] = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    logic [2:0] seq [4];
    logic [2:0] prev;
    logic [2:0] dn;
    int         ng;
    int         jumps;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tmo_n[0] = 4; tmo_n[1] = 3;
        rr_n[0]  = 1'b1; rr_n[1] = 1'b0;
        sdat_rand = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = '0; stb[d] = '0; we[d] = '0; sel[d] = '0;
            adr[d] = '0; wdat[d] = '0; sdat[d] = '0; sack[d] = 1'b0;
            ack_mode[d] = 0;
            model_reset(d);
        end
        for (int i = 0; i < 4; i++) seq[i] = 3'b000;

        // Reset state
        @(negedge clk);
        settle();
        chk(0, "rst_gnt", o_gnt[0], 3'b000);
        chk(0, "rst_sstb", o_sstb[0], 1'b0);
        chk(0, "rst_tadr", o_tadr[0], 16'h0000);
        adv();
        rst_n = 1'b1;
        step();

        // Single request from m0, acked with 0x1234
        cyc[0] = 3'b001; stb[0] = 3'b001; we[0] = 3'b000;
        adr[0] = 48'h0;
        adr[0][15:0] = 16'o177716;
        sdat[0] = 16'h1234;
        settle();
        chk(0, "t1_gnt_lat", o_gnt[0], 3'b000);
        adv();
        settle();
        chk(0, "t1_gnt", o_gnt[0], 3'b001);
        chk(0, "t1_sadr", o_sadr[0], 16'o177716);
        adv();
        ack_mode[0] = 1;
        settle();
        chk(0, "t1_ack", o_ack[0], 3'b001);
        chk(0, "t1_mdat", o_mdat[0], 16'h1234);
        adv();
        idle(3);
        chk(0, "t1_release", o_gnt[0], 3'b000);

        // Round-robin rotation with all three masters requesting
        do_reset();
        cyc[0] = 3'b111; stb[0] = 3'b111; ack_mode[0] = 1;
        ng = 0; prev = 3'b000; jumps = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            settle();
            if (o_gnt[0] != 3'b000 && prev == 3'b000) begin
                seq[ng] = o_gnt[0];
                ng++;
            end
            if (o_gnt[0] != 3'b000 && prev != 3'b000 && o_gnt[0] != prev) jumps++;
            prev = o_gnt[0];
            dn = done[0];
            adv();
            cyc[0] = ~dn;
            stb[0] = ~dn;
        end
        chk(0, "rr_count", 64'(ng), 64'd4);
        chk(0, "rr_1st", seq[0], 3'b001);
        chk(0, "rr_2nd", seq[1], 3'b010);
        chk(0, "rr_3rd", seq[2], 3'b100);
        chk(0, "rr_4th", seq[3], 3'b001);
        chk(0, "rr_no_gap_switch", 64'(jumps), 64'd0);
        idle(3);

        // Fixed priority: m1 keeps the bus, then m0 beats an earlier m2
        cyc[1] = 3'b010;
        step();
        settle();
        chk(1, "fp_m1_gnt", o_gnt[1], 3'b010);
        adv();
        cyc[1] = 3'b110;
        step();
        cyc[1] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk(1, "fp_hold", o_gnt[1], 3'b010);
            adv();
        end
        cyc[1] = 3'b101;
        step();
        settle();
        chk(1, "fp_gap", o_gnt[1], 3'b000);
        adv();
        settle();
        chk(1, "fp_m0_next", o_gnt[1], 3'b001);
        adv();
        cyc[1] = 3'b100;
        step();
        step();
        settle();
        chk(1, "fp_m2_last", o_gnt[1], 3'b100);
        adv();
        idle(3);

        // Timeout on m2 at 0x8000 with no slave reply
        cyc[0] = 3'b100; stb[0] = 3'b100;
        adr[0] = 48'h0;
        adr[0][47:32] = 16'h8000;
        step();
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk(0, "tmo_stall_stb", o_sstb[0], 1'b1);
            chk(0, "tmo_no_early_err", o_err[0], 3'b000);
            adv();
        end
        settle();
        chk(0, "tmo_err", o_err[0], 3'b100);
        chk(0, "tmo_pulse", o_tmo[0], 1'b1);
        chk(0, "tmo_adr", o_tadr[0], 16'h8000);
        chk(0, "tmo_blk_stb", o_sstb[0], 1'b0);
        adv();
        for (int k = 0; k < 6; k++) begin
            settle();
            chk(0, "tmo_once", o_err[0], 3'b000);
            chk(0, "tmo_blk_hold", o_sstb[0], 1'b0);
            adv();
        end
        stb[0] = 3'b000;
        step();
        stb[0] = 3'b100;
        settle();
        chk(0, "tmo_blk_clear", o_sstb[0], 1'b1);
        adv();
        idle(3);
        chk(0, "tmo_adr_kept", o_tadr[0], 16'h8000);

        // Ack arriving in the cycle the timeout would fire
        cyc[0] = 3'b001; stb[0] = 3'b001;
        adr[0] = 48'h0;
        adr[0][15:0] = 16'h0042;
        step();
        for (int k = 1; k <= 3; k++) step();
        ack_mode[0] = 1;
        settle();
        chk(0, "bnd_ack", o_ack[0], 3'b001);
        adv();
        ack_mode[0] = 0;
        settle();
        chk(0, "bnd_no_err", o_err[0], 3'b000);
        chk(0, "bnd_no_tmo", o_tmo[0], 1'b0);
        adv();
        idle(3);

        // Asynchronous reset while m1 is granted and strobing
        cyc[0] = 3'b010; stb[0] = 3'b010;
        step();
        step();
        settle();
        chk(0, "ar_pre_stb", o_sstb[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk(0, "ar_gnt", o_gnt[0], 3'b000);
        chk(0, "ar_sstb", o_sstb[0], 1'b0);
        for (int d = 0; d < 2; d++) model_reset(d);
        adv();
        cyc[0] = 3'b011; stb[0] = 3'b000;
        rst_n = 1'b1;
        settle();
        chk(0, "ar_idle", o_gnt[0], 3'b000);
        adv();
        settle();
        chk(0, "ar_m0_first", o_gnt[0], 3'b001);
        adv();
        idle(3);

        // Randomized traffic on both instances
        sdat_rand = 1'b1;
        ack_mode[0] = 2; ack_mode[1] = 2;
        for (int c = 0; c < 4000; c++) begin
            agent(0);
            agent(1);
            settle();
            if (c == 2000) begin
                #1 rst_n = 1'b0;
                #1;
                chk(0, "rnd_rst_gnt", o_gnt[0], 3'b000);
                chk(1, "rnd_rst_gnt", o_gnt[1], 3'b000);
                for (int d = 0; d < 2; d++) model_reset(d);
                adv();
                rst_n = 1'b1;
            end else begin
                adv();
            end
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wbm_arb3.md
Name: wbm_arb3

Overview:
- Three-master Wishbone arbiter that shares the single 16-bit system bus among the VM1 processor thunk (master 0), a DMA engine (master 1) and the debug/loader port (master 2).
- It produces each master's grant (the VM1 thunk's wbm_gnt_i), multiplexes the granted master onto the slave bus, and routes ack back to that master.
- It runs a no-reply timeout so that a stalled access ends with an error pulse instead of hanging the bus, in the same way Q-bus reports nonexistent memory.

Parameters:
- TMO_CYCLES, 255: clock cycles of s_stb_o without s_ack_i before a timeout error (1..255, held in an 8-bit counter).
- RR, 1: arbitration policy. 1 = round-robin; 0 = fixed priority, m0 highest.

Ports:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- m_cyc_i  in  3  per-master cycle request; bit n belongs to master n.
- m_stb_i  in  3  per-master strobe.
- m_we_i  in  3  per-master write enable.
- m_sel_i  in  6  byte selects, {m2,m1,m0}, 2 bits each.
- m_adr_i  in  48  addresses, {m2,m1,m0}, 16 bits each.
- m_dat_i  in  48  write data, {m2,m1,m0}, 16 bits each.
- m_dat_o  out  16  read data, broadcast to all masters.
- m_ack_o  out  3  per-master acknowledge.
- m_err_o  out  3  per-master timeout error, one-cycle pulse.
- m_gnt_o  out  3  per-master grant (registered, one-hot or zero).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave bus controls.
- s_sel_o  out  2  slave byte select.
- s_adr_o  out  16  slave address.
- s_dat_o  out  16  slave write data.
- s_dat_i  in  16  slave read data.
- s_ack_i  in  1  slave acknowledge.
- tmo_o  out  1  timeout event pulse.
- tmo_adr_o  out  16  address of the last timed-out access.

Behaviour:
- Reset (async, while wb_rst_n = 0):
  - state = IDLE; m_gnt_o = 0; m_ack_o = 0; m_err_o = 0; tmo_o = 0; tmo_adr_o = 0.
  - Timeout counter = 0; block flag = 0; RR pointer last = 2, so m0 wins first.
  - All s_* outputs are 0 because they are gated by grant.
- States: IDLE, OWN.
- IDLE:
  - If m_cyc_i != 0, pick winner W and on the next edge set m_gnt_o[W] = 1, own = W, state = OWN.
  - Grant latency: one cycle from cyc rising to gnt.
  - RR = 1: search order is last+1, last+2, last (mod 3); last <= W on grant.
  - RR = 0: lowest index wins.
- OWN:
  - s_cyc_o = m_cyc_i[own]; s_stb_o = m_stb_i[own] & ~blk.
  - s_we_o, s_sel_o, s_adr_o, s_dat_o = fields of master own. Combinational mux on the registered own.
  - m_ack_o[own] = s_ack_i (combinational); other ack bits = 0. m_dat_o = s_dat_i always.
  - When m_cyc_i[own] = 0: next edge clears gnt and moves to IDLE.
  - Arbitration then happens in IDLE, so there is at least one gnt-low cycle between owners. No back-to-back ownership change.
- Grant is never revoked while the owner holds cyc. No preemption, including by m0 in fixed mode.
- Owner dropping cyc while stb is high: release anyway. Any ack arriving after release is discarded (gnt = 0, so no m_ack_o).
- Timeout:
  - cnt increments each cycle s_stb_o & ~s_ack_i; it clears when s_stb_o = 0 or s_ack_i = 1.
  - When cnt == TMO_CYCLES-1 and the stall continues, on the next edge: m_err_o[own] = 1 for exactly one cycle, tmo_o = 1 for one cycle, tmo_adr_o <= s_adr_o, cnt <= 0, blk <= 1.
  - With TMO_CYCLES = N, err rises at edge N after stb.
  - blk forces s_stb_o low and holds until m_stb_i[own] = 0 or m_cyc_i[own] = 0. This prevents repeated errors on the same access.
  - s_ack_i in the same cycle the timeout would fire: ack wins, no err, counter clears.
- m_err_o is registered; m_ack_o is combinational. The two are never high in the same cycle for the same master.
- Reset asserted mid-cycle: all outputs drop asynchronously. After release the arbiter starts in IDLE and must see cyc again.

Test Plan:
- Single request: m0 raises cyc/stb with adr = 16'o177716, we = 0 -> m_gnt_o = 3'b001 one cycle later, s_adr_o = 16'o177716. Slave ack with s_dat_i = 16'h1234 -> m_ack_o[0] = 1 and m_dat_o = 16'h1234 in the same cycle.
- Round-robin, RR = 1, all three cyc held high, each owner drops cyc after one acked access -> grant order 001, 010, 100, 001, with one gnt-low cycle between owners.
- Fixed priority, RR = 0, m1 owns the bus and m0 requests -> m1 keeps grant until it drops cyc. Next grant goes to m0 even though m2 requested earlier.
- Timeout, TMO_CYCLES = 4, m2 strobes adr = 16'h8000 with no ack -> m_err_o[2] and tmo_o pulse at edge 4; tmo_adr_o = 16'h8000; s_stb_o = 0 until m2 drops stb; no second error.
- Ack on the boundary: TMO_CYCLES = 4, s_ack_i arrives in the cycle the timeout would fire -> m_ack_o pulses, no m_err_o, no tmo_o.
- Reset while m1 is granted and s_stb_o = 1 -> m_gnt_o = 0 and s_stb_o = 0 immediately. After release with m0 and m1 both requesting, m0 is granted first.
